// File: rtl/inter_tier_spread_engine.sv
// Inter-tier spread charge engine: buckets signed positions into maturity tiers,
// nets intra-tier, then across tier pairs, then charges outright on the residue.
module inter_tier_spread_engine #(
    parameter int NUM_POS   = 8,
    parameter int NUM_TIERS = 3,
    parameter int POS_W     = 16,
    parameter int MAT_W     = 8,
    parameter int CHG_W     = 8,
    parameter int TSC_W     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [POS_W-1:0] position     [NUM_POS],
    input  logic [MAT_W-1:0] maturity     [NUM_POS],
    input  logic [MAT_W-1:0] tier_max     [NUM_TIERS],
    input  logic [CHG_W-1:0] intra_chg    [NUM_TIERS],
    input  logic [CHG_W-1:0] inter_chg    [NUM_TIERS*(NUM_TIERS-1)/2],
    input  logic [CHG_W-1:0] outright_chg [NUM_TIERS],
    output logic             busy,
    output logic             done,
    output logic [TSC_W-1:0] tsc
);
    localparam int NUM_PAIRS = NUM_TIERS * (NUM_TIERS - 1) / 2;
    localparam int SUM_W     = POS_W + $clog2(NUM_POS);
    localparam int PROD_W    = SUM_W + 1 + CHG_W;
    localparam int ADD_W     = ((TSC_W > PROD_W) ? TSC_W : PROD_W) + 1;
    localparam int PI_W      = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
    localparam int TI_W      = (NUM_TIERS > 1) ? $clog2(NUM_TIERS) : 1;
    localparam int PP_W      = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_INTRA, S_INTER, S_OUTR, S_DONE} state_t;

    state_t           state_q;
    logic [POS_W-1:0] pos_q   [NUM_POS];
    logic [MAT_W-1:0] mat_q   [NUM_POS];
    logic [MAT_W-1:0] tmax_q  [NUM_TIERS];
    logic [CHG_W-1:0] intra_q [NUM_TIERS];
    logic [CHG_W-1:0] inter_q [NUM_PAIRS];
    logic [CHG_W-1:0] outr_q  [NUM_TIERS];
    logic [SUM_W-1:0] long_q  [NUM_TIERS];
    logic [SUM_W-1:0] short_q [NUM_TIERS];
    logic [TSC_W-1:0] tsc_q;
    logic             busy_q, done_q;
    logic [PI_W-1:0]  pidx_q;
    logic [TI_W-1:0]  ti_q, tj_q;
    logic [PP_W-1:0]  pp_q;

    logic [POS_W-1:0] cur_pos;
    logic [MAT_W-1:0] cur_mat;
    logic             hit;
    logic [TI_W-1:0]  tsel;
    logic [POS_W:0]   posx, mag;
    logic [SUM_W-1:0] m_in, a_pr, b_pr;
    logic [PROD_W-1:0] prod;
    logic [ADD_W-1:0] sum;
    logic [TSC_W-1:0] tsc_d;

    always_comb begin
        cur_pos = pos_q[pidx_q];
        cur_mat = mat_q[pidx_q];
        hit     = 1'b0;
        tsel    = '0;
        // First match wins, so a non-ascending bound table is still well defined
        for (int unsigned t = 0; t < NUM_TIERS; t++) begin
            if (!hit && (cur_mat < tmax_q[t])) begin
                hit  = 1'b1;
                tsel = TI_W'(t);
            end
        end
        posx = {cur_pos[POS_W-1], cur_pos};
        mag  = cur_pos[POS_W-1] ? ('0 - posx) : posx;

        m_in = (long_q[ti_q] < short_q[ti_q]) ? long_q[ti_q] : short_q[ti_q];
        a_pr = (long_q[ti_q] < short_q[tj_q]) ? long_q[ti_q] : short_q[tj_q];
        b_pr = (short_q[ti_q] < long_q[tj_q]) ? short_q[ti_q] : long_q[tj_q];

        case (state_q)
            S_INTRA: prod = PROD_W'(m_in) * PROD_W'(intra_q[ti_q]);
            S_INTER: prod = (PROD_W'(a_pr) + PROD_W'(b_pr)) * PROD_W'(inter_q[pp_q]);
            S_OUTR:  prod = (PROD_W'(long_q[ti_q]) + PROD_W'(short_q[ti_q]))
                            * PROD_W'(outr_q[ti_q]);
            default: prod = '0;
        endcase
        sum   = ADD_W'(tsc_q) + ADD_W'(prod);
        tsc_d = (|sum[ADD_W-1:TSC_W]) ? '1 : sum[TSC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tsc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pidx_q  <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            pp_q    <= '0;
            for (int unsigned i = 0; i < NUM_POS; i++) begin
                pos_q[i] <= '0;
                mat_q[i] <= '0;
            end
            for (int unsigned t = 0; t < NUM_TIERS; t++) begin
                tmax_q[t]  <= '0;
                intra_q[t] <= '0;
                outr_q[t]  <= '0;
                long_q[t]  <= '0;
                short_q[t] <= '0;
            end
            for (int unsigned p = 0; p < NUM_PAIRS; p++) inter_q[p] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    pos_q   <= position;
                    mat_q   <= maturity;
                    tmax_q  <= tier_max;
                    intra_q <= intra_chg;
                    inter_q <= inter_chg;
                    outr_q  <= outright_chg;
                    for (int unsigned t = 0; t < NUM_TIERS; t++) begin
                        long_q[t]  <= '0;
                        short_q[t] <= '0;
                    end
                    tsc_q   <= '0;
                    pidx_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    if (hit && (cur_pos != '0)) begin
                        if (cur_pos[POS_W-1]) short_q[tsel] <= short_q[tsel] + SUM_W'(mag);
                        else                  long_q[tsel]  <= long_q[tsel] + SUM_W'(mag);
                    end
                    if (pidx_q == PI_W'(NUM_POS - 1)) begin
                        ti_q    <= '0;
                        state_q <= S_INTRA;
                    end else begin
                        pidx_q <= pidx_q + PI_W'(1);
                    end
                end
                S_INTRA: begin
                    tsc_q         <= tsc_d;
                    long_q[ti_q]  <= long_q[ti_q] - m_in;
                    short_q[ti_q] <= short_q[ti_q] - m_in;
                    if (ti_q == TI_W'(NUM_TIERS - 1)) begin
                        ti_q    <= '0;
                        tj_q    <= TI_W'(1);
                        pp_q    <= '0;
                        state_q <= S_INTER;
                    end else begin
                        ti_q <= ti_q + TI_W'(1);
                    end
                end
                S_INTER: begin
                    tsc_q         <= tsc_d;
                    long_q[ti_q]  <= long_q[ti_q] - a_pr;
                    short_q[tj_q] <= short_q[tj_q] - a_pr;
                    short_q[ti_q] <= short_q[ti_q] - b_pr;
                    long_q[tj_q]  <= long_q[tj_q] - b_pr;
                    if (pp_q == PP_W'(NUM_PAIRS - 1)) begin
                        ti_q    <= '0;
                        state_q <= S_OUTR;
                    end else begin
                        pp_q <= pp_q + PP_W'(1);
                        if (tj_q == TI_W'(NUM_TIERS - 1)) begin
                            ti_q <= ti_q + TI_W'(1);
                            tj_q <= ti_q + TI_W'(2);
                        end else begin
                            tj_q <= tj_q + TI_W'(1);
                        end
                    end
                end
                S_OUTR: begin
                    tsc_q <= tsc_d;
                    if (ti_q == TI_W'(NUM_TIERS - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        ti_q <= ti_q + TI_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign tsc  = tsc_q;
endmodule

// File: tb/tb_inter_tier_spread_engine.sv
// Directed bench for inter_tier_spread_engine: default build plus a 16-bit TSC
// build sharing the same stimulus, checked against hand-computed charges.
module tb_inter_tier_spread_engine;
    localparam int NP = 8, NT = 3, NPR = 3;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] position     [NP];
    logic [7:0]  maturity     [NP];
    logic [7:0]  tier_max     [NT];
    logic [7:0]  intra_chg    [NT];
    logic [7:0]  inter_chg    [NPR];
    logic [7:0]  outright_chg [NT];
    logic        busy, done, busy16, done16;
    logic [23:0] tsc;
    logic [15:0] tsc16;
    int          nvec = 0, nerr = 0;
    int          dn, lat;

    always #5 clk = ~clk;

    inter_tier_spread_engine dut (
        .clk(clk), .reset(reset), .start(start), .position(position), .maturity(maturity),
        .tier_max(tier_max), .intra_chg(intra_chg), .inter_chg(inter_chg),
        .outright_chg(outright_chg), .busy(busy), .done(done), .tsc(tsc)
    );

    inter_tier_spread_engine #(.TSC_W(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .position(position), .maturity(maturity),
        .tier_max(tier_max), .intra_chg(intra_chg), .inter_chg(inter_chg),
        .outright_chg(outright_chg), .busy(busy16), .done(done16), .tsc(tsc16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NP; i++) begin
            position[i] = '0;
            maturity[i] = '0;
        end
        for (int t = 0; t < NT; t++) begin
            intra_chg[t]    = '0;
            outright_chg[t] = '0;
            inter_chg[t]    = '0;
        end
        tier_max[0] = 8'd4;
        tier_max[1] = 8'd8;
        tier_max[2] = 8'd12;
    endtask

    task automatic set_charges(input logic [7:0] v);
        for (int t = 0; t < NT; t++) begin
            intra_chg[t]    = v;
            inter_chg[t]    = v;
            outright_chg[t] = v;
        end
    endtask

    task automatic setup_intra();
        clear_inputs();
        set_charges(8'd9);
        position[0] = 16'd10;   maturity[0] = 8'd1;
        position[1] = 16'hFFFC; maturity[1] = 8'd2;
        intra_chg[0] = 8'd5;
        outright_chg[0] = 8'd2;
    endtask

    // Called from an IDLE cycle, #1 after an edge; returns in the DONE cycle.
    task automatic run(input string tag, input logic [31:0] exp24, input logic [31:0] exp16,
                       input bit scramble);
        int n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        if (scramble) begin
            for (int i = 0; i < NP; i++) begin
                position[i] = 16'($urandom);
                maturity[i] = 8'd1;
            end
            set_charges(8'd200);
        end
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        // done is high in cycle k+18, i.e. just after the 17th edge past acceptance
        chk({tag, "_latency"}, n, 17);
        chk({tag, "_done16"}, done16, 1);
        chk({tag, "_tsc"}, tsc, exp24);
        chk({tag, "_tsc16"}, tsc16, exp16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tsc", tsc, 0);
        chk("rst_tsc16", tsc16, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Intra only: 4*5 + 6*2
        setup_intra();
        run("intra", 32, 32, 0);
        @(posedge clk); #1;
        chk("hold_idle", tsc, 32);

        // Start in the IDLE cycle right after DONE; inputs scrambled after capture
        clear_inputs();
        set_charges(8'd50);
        position[0] = 16'd5;    maturity[0] = 8'd1;
        position[1] = 16'hFFFD; maturity[1] = 8'd5;
        position[2] = 16'hFFFC; maturity[2] = 8'd9;
        position[3] = 16'd1;    maturity[3] = 8'd10;
        intra_chg[2] = 8'd3;
        inter_chg[0] = 8'd7; inter_chg[1] = 8'd6; inter_chg[2] = 8'd9;
        outright_chg[2] = 8'd10;
        run("chain", 46, 46, 1);
        @(posedge clk); #1;

        // Reverse direction: short in tier 0 against long in tier 1
        clear_inputs();
        intra_chg[0] = 8'd11; intra_chg[1] = 8'd12; intra_chg[2] = 8'd13;
        inter_chg[0] = 8'd4;  inter_chg[1] = 8'd15; inter_chg[2] = 8'd16;
        outright_chg[0] = 8'd17; outright_chg[1] = 8'd18; outright_chg[2] = 8'd19;
        position[0] = 16'hFFFA; maturity[0] = 8'd1;
        position[1] = 16'd6;    maturity[1] = 8'd5;
        run("reverse", 24, 24, 0);
        @(posedge clk); #1;

        // Every maturity equals the last exclusive bound: all dropped
        clear_inputs();
        set_charges(8'd7);
        for (int i = 0; i < NP; i++) begin
            position[i] = (i % 2 == 0) ? 16'((i + 1) * 100) : 16'(-((i + 1) * 100));
            maturity[i] = 8'd12;
        end
        run("dropped", 0, 0, 0);
        @(posedge clk); #1;

        // Saturation: 32767*255 + 1*3 fits 24 bits, clamps 16 bits
        clear_inputs();
        set_charges(8'd1);
        position[0] = 16'h7FFF; maturity[0] = 8'd1;
        position[1] = 16'h8000; maturity[1] = 8'd1;
        intra_chg[0] = 8'd255;
        outright_chg[0] = 8'd3;
        run("sat", 32'd8355588, 32'hFFFF, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold16", tsc16, 32'hFFFF);

        // Non-ascending bounds: mat 2 matches tier 0 first, not tier 1
        clear_inputs();
        set_charges(8'd5);
        tier_max[0] = 8'd10; tier_max[1] = 8'd4; tier_max[2] = 8'd12;
        inter_chg[0] = 8'd1; inter_chg[1] = 8'd7; inter_chg[2] = 8'd1;
        position[0] = 16'd3;    maturity[0] = 8'd2;
        position[1] = 16'hFFFD; maturity[1] = 8'd11;
        run("nonasc", 21, 21, 0);
        @(posedge clk); #1;

        // start at k+5 and on the DONE cycle are both ignored
        setup_intra();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dn = 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                dn++;
                if (lat == 0) lat = n;
                start = 1'b1;
            end
        end
        chk("hs_done_count", dn, 1);
        chk("hs_latency", lat, 17);
        chk("hs_tsc", tsc, 32);
        chk("hs_busy", busy, 0);

        // Reset asserted at k+10 of a fresh run
        setup_intra();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tsc", tsc, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_tsc16", tsc16, 0);
        reset = 1'b1;
        dn = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || done16) dn++;
        end
        chk("mid_rst_no_done", dn, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
